// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: iterative AES-128 SubBytes. Substitutes one 32-bit column of
// the 128-bit state per clock through four forward S-box lookups. The result
// is held until the consumer accepts it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   inmatrix   128-bit input state, byte 0 = [127:120], column c = [127-32c -: 32]
//   in_valid   inmatrix is valid
//   in_ready   block can accept. Combinational from out_ready while DONE.
//   outmatrix  substituted state, valid while out_valid = 1
//   out_valid  complete result available
//   out_ready  consumer takes the result
module sub_bytes_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] inmatrix,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] outmatrix,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned BYTE_W  = 8;

  // FIPS-197 forward S-box. Entry 0 occupies the top byte.
  localparam logic [2047:0] SBOX_LUT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [STATE_W-1:0]   st;
  logic [STATE_W-1:0]   st_sub;
  logic [1:0]           col;
  logic [COL_W-1:0]     col_word;
  logic [COL_W-1:0]     sub_word;
  logic                 accept;

  // Entry b lives at bit offset (255-b)*8, and 255-b equals ~b for a byte.
  function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] b);
    sbox = SBOX_LUT[{~b, 3'b000} +: BYTE_W];
  endfunction

  assign accept    = in_valid & in_ready;
  assign outmatrix = st;

  // Select the column currently being substituted.
  always_comb begin
    col_word = st[127:96];
    unique case (col)
      2'd0: col_word = st[127:96];
      2'd1: col_word = st[95:64];
      2'd2: col_word = st[63:32];
      2'd3: col_word = st[31:0];
      default: col_word = st[127:96];
    endcase
  end

  // Four S-box lookups, one per byte of the column.
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign sub_word[COL_W-1-BYTE_W*g -: BYTE_W] = sbox(col_word[COL_W-1-BYTE_W*g -: BYTE_W]);
  end

  // Merge the substituted column back into the state. The other columns hold.
  always_comb begin
    st_sub = st;
    unique case (col)
      2'd0: st_sub[127:96] = sub_word;
      2'd1: st_sub[95:64]  = sub_word;
      2'd2: st_sub[63:32]  = sub_word;
      2'd3: st_sub[31:0]   = sub_word;
      default: st_sub = st;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: if (col == 2'd3) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs. The DONE->BUSY overlap needs in_ready to follow out_ready.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    unique case (state)
      IDLE: in_ready = ~rst;
      BUSY: in_ready = 1'b0;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = ~rst & out_ready;
      end
      default: begin
        out_valid = 1'b0;
        in_ready  = 1'b0;
      end
    endcase
  end

  // Working state and column counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= '0;
      col <= 2'd0;
    end else if (accept) begin
      st  <= inmatrix;
      col <= 2'd0;
    end else if (state == BUSY) begin
      st  <= st_sub;
      col <= col + 2'd1;
    end
  end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Testbench for sub_bytes_seq. The bench builds a reference S-box from GF(2^8)
// inversion plus the affine map. A transaction-level model predicts the
// handshakes and the result of each block. One negedge process compares the
// DUT against the model every cycle, and directed literal vectors pin the model.
module tb_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] inmatrix = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] outmatrix;
  logic         out_valid;
  logic         out_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ONE_IN   = 128'h0000000000530000_0000000000000000;
  localparam logic [127:0] ONE_OUT  = 128'h6363636363ed6363_6363636363636363;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub_bytes_seq dut (
    .clk      (clk),
    .rst      (rst),
    .inmatrix (inmatrix),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .outmatrix(outmatrix),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // ---------------- reference S-box from field arithmetic ----------------
  logic [7:0] sb_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb_tab[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] sub_all(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = sb_tab[x[127-8*i -: 8]];
    return y;
  endfunction

  // ---------------- transaction-level model ----------------
  // A block counts as pending from acceptance until the output transfer.
  // Its result becomes visible 4 cycles after acceptance.
  logic         m_pend = 1'b0;
  logic         m_zero = 1'b1;
  int           m_age  = 0;
  logic [127:0] m_exp  = '0;
  logic         exp_valid;
  logic         exp_in_ready;

  assign exp_valid    = m_pend && (m_age >= 4);
  assign exp_in_ready = !rst && (!m_pend || (exp_valid && out_ready));

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_zero <= 1'b1;
      m_age  <= 0;
    end else if (in_valid && exp_in_ready) begin
      m_pend <= 1'b1;
      m_age  <= 0;
      m_exp  <= sub_all(inmatrix);
      m_zero <= 1'b0;
    end else if (exp_valid && out_ready) begin
      m_pend <= 1'b0;
    end else if (m_pend) begin
      m_age <= m_age + 1;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc in_ready", 128'(in_ready), 128'(exp_in_ready));
    chk("cyc out_valid", 128'(out_valid), 128'(exp_valid));
    if (exp_valid) chk("cyc outmatrix", outmatrix, m_exp);
    if (m_zero) chk("cyc outmatrix zero", outmatrix, 128'h0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one block with out_ready high. Check latency, data and a one-cycle valid.
  task automatic run_vec(input logic [127:0] d, input logic [127:0] exp, input string nm);
    int lat;
    inmatrix = d; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({nm, " latency"}, 128'(lat), 128'(4));
    chk({nm, " data"}, outmatrix, exp);
    step();
    chk({nm, " single valid"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held;
    logic [127:0] blk [3];
    logic [127:0] blk_exp [3];
    logic [127:0] got [3];
    int tout [3];
    int nacc, nout, guard, nblk, w;
    logic acc;

    build_sbox();

    // Pin the model against hand-known values.
    chk("model zeros", sub_all(128'h0), {16{8'h63}});
    chk("model ones", sub_all({128{1'b1}}), {16{8'h16}});
    chk("model fips", sub_all(FIPS_IN), FIPS_OUT);

    // Reset state.
    rst = 1'b1;
    repeat (2) step();
    chk("in_ready during rst", 128'(in_ready), 128'(0));
    rst = 1'b0;
    #1;
    chk("rst out_valid", 128'(out_valid), 128'(0));
    chk("rst outmatrix", outmatrix, 128'h0);
    chk("rst in_ready", 128'(in_ready), 128'(1));

    // Known-answer vectors.
    run_vec(FIPS_IN, FIPS_OUT, "fips");
    run_vec(128'h0, {16{8'h63}}, "zeros");
    run_vec({128{1'b1}}, {16{8'h16}}, "ones");
    run_vec(ONE_IN, ONE_OUT, "byte5");

    // Backpressure: hold out_ready low for 10 cycles with in_valid asserted.
    inmatrix = ONE_IN; in_valid = 1'b1; out_ready = 1'b0;
    step();
    inmatrix = FIPS_IN;
    w = 0;
    while (!out_valid && w < 20) begin
      step();
      w++;
    end
    chk("bp latency", 128'(w), 128'(4));
    held = outmatrix;
    chk("bp data", held, ONE_OUT);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp out_valid", 128'(out_valid), 128'(1));
      chk("bp outmatrix stable", outmatrix, held);
      chk("bp in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp release", 128'(out_valid), 128'(0));

    // Back-to-back: three blocks with overlapped accept and output transfer.
    blk[0] = FIPS_IN;     blk_exp[0] = FIPS_OUT;
    blk[1] = 128'h0;      blk_exp[1] = {16{8'h63}};
    blk[2] = ONE_IN;      blk_exp[2] = ONE_OUT;
    nacc = 0; nout = 0; guard = 0;
    out_ready = 1'b1; in_valid = 1'b1; inmatrix = blk[0];
    while (nout < 3 && guard < 60) begin
      if (out_valid && out_ready) begin
        got[nout]  = outmatrix;
        tout[nout] = cyc;
        nout++;
      end
      acc = in_valid && in_ready;
      step();
      guard++;
      if (acc) begin
        nacc++;
        if (nacc < 3) inmatrix = blk[nacc];
        else in_valid = 1'b0;
      end
    end
    chk("b2b count", 128'(nout), 128'(3));
    if (nout == 3) begin
      for (int i = 0; i < 3; i++) chk("b2b data", got[i], blk_exp[i]);
      chk("b2b spacing 0-1", 128'(tout[1] - tout[0]), 128'(5));
      chk("b2b spacing 1-2", 128'(tout[2] - tout[1]), 128'(5));
    end
    step();

    // Reset in the second BUSY cycle.
    inmatrix = ONE_IN; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("midrst in_ready held", 128'(in_ready), 128'(0));
    step();
    chk("midrst out_valid", 128'(out_valid), 128'(0));
    chk("midrst outmatrix", outmatrix, 128'h0);
    rst = 1'b0;
    #1;
    chk("midrst in_ready after", 128'(in_ready), 128'(1));
    run_vec(FIPS_IN, FIPS_OUT, "post-rst");

    // Randomized blocks with random stalls on both sides.
    nblk = 0; guard = 0;
    while (nblk < 1000 && guard < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      inmatrix  = {$urandom(), $urandom(), $urandom(), $urandom()};
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) nblk++;
      step();
      guard++;
    end
    chk("random blocks accepted", 128'(nblk), 128'(1000));
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sub_bytes_seq.md
# sub_bytes_seq

Iterative AES-128 SubBytes stage that applies the FIPS-197 forward S-box to all 16 bytes of a 128-bit state, one column (4 bytes) per clock, using four S-box instances. It sits directly upstream of the ShiftRows stage in the encryption round datapath: its `outmatrix` feeds ShiftRows `inmatrix` unchanged. Valid/ready handshakes on both sides let the round controller stall it.

## Interface
- No parameters; the state width is fixed at 128 bits and the column count at 4.
- `clk` in 1 — sole clock, rising-edge.
- `rst` in 1 — synchronous, active-high reset.
- `inmatrix` in 128 — input state, column-major: byte 0 = [127:120], column c = bits [127-32c : 96-32c].
- `in_valid` in 1 — `inmatrix` is valid.
- `in_ready` out 1 — block can accept; transfer occurs on a rising edge with `in_valid & in_ready`.
- `outmatrix` out 128 — substituted state, same byte layout as `inmatrix`.
- `out_valid` out 1 — `outmatrix` holds a complete result.
- `out_ready` in 1 — consumer takes the result; transfer occurs on an edge with `out_valid & out_ready`.

## Operation
- Registers: 128-bit working register `st`; 2-bit column counter `col`; state register in {IDLE, BUSY, DONE}.
- `outmatrix` = `st` at all times. It is meaningful only while `out_valid` = 1.
- `out_valid` = (state == DONE).
- `in_ready` = !rst & ((state == IDLE) | (state == DONE & out_ready)). This is a combinational path from `out_ready` to `in_ready`.
- IDLE:
  - on accept: `st` ← `inmatrix`, `col` ← 0, go to BUSY.
  - otherwise hold.
- BUSY:
  - each cycle, the four bytes of column `col` in `st` are replaced by S(byte). Other columns hold.
  - `col` increments (2-bit, wraps to 0).
  - when `col` == 3, go to DONE after that substitution.
  - `in_valid` and `out_ready` are ignored; `in_ready` = 0.
- DONE: `st` holds.
  - on `out_ready` = 1 without `in_valid`: go to IDLE.
  - on `out_ready` = 1 with `in_valid` (simultaneous output and input transfer): load the new `inmatrix`, `col` ← 0, go to BUSY.
  - on `out_ready` = 0: hold state and data indefinitely; `in_ready` = 0.
- S-box: bit-exact to the FIPS-197 forward table. Either a 256-entry constant LUT or GF(2^8) inversion plus affine transform is acceptable. It is purely combinational, with four identical instances.
- Reset (`rst` = 1 at an edge) is taken from any state, including mid-BUSY:
  - state ← IDLE, `col` ← 0, `st` ← 0.
  - any in-flight block is discarded with no output.
  - outputs after reset: `outmatrix` = 0, `out_valid` = 0, `in_ready` = 1 (0 while `rst` is held high).

## Timing
- Accept at edge E0. Columns 0, 1, 2, 3 are substituted at edges E1, E2, E3, E4.
- `out_valid` rises after E4. Latency is 4 cycles from the accepting edge to the first cycle of `out_valid`.
- Minimum period between accepts is 5 cycles with back-to-back handshakes: accept, 3 further BUSY cycles, then a DONE cycle that overlaps the output transfer and the next accept.
- `outmatrix` is stable from the rise of `out_valid` until the output transfer edge.
- No combinational path from `inmatrix` to `outmatrix`.

## Test plan
- **FIPS-197 App. B, round 1.** Drive `inmatrix`=193de3bea0f4e22b9ac68d2ae9f84808 with `out_ready`=1. Required: `outmatrix`=d42711aee0bf98f1b8b45de51e415230, with `out_valid` high exactly 4 cycles after accept, for one cycle.
- **Constants.** All-zero input → 63636363…63 (16 bytes). All-ones input → 1616…16. A single byte 0x53 at byte 5, other bytes 0x00 → byte 5 = 0xed, all others 0x63.
- **Backpressure.** Hold `out_ready`=0 for 10 cycles after `out_valid`. Required: `out_valid` and `outmatrix` stay constant, and `in_ready`=0 with `in_valid` asserted.
- **Back-to-back.** Run three blocks, raising `in_valid` with new data in the DONE cycle while `out_ready`=1. Required: each output transferred once, in order, at 5-cycle spacing, with no block dropped.
- **Reset mid-operation.** Assert `rst` at the 2nd BUSY cycle. Required: next cycle `out_valid`=0 and `outmatrix`=0; after `rst` drops, `in_ready`=1 and the next block produces its correct result.
- **Randomized.** 1000 random states with random `in_valid`/`out_ready` stalls, checked against a reference S-box model byte-for-byte.
